// File: rtl/shared_adder_arbiter_if.sv
// Request/response bundle between requesters, the shared adder arbiter and the result consumer.
// Optional macro SUMADOR_FLAGS_EN adds the resp_cout/resp_ovf result flags.
interface shared_adder_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;
    logic                  resp_ready;
`ifdef SUMADOR_FLAGS_EN
    logic                  resp_cout;
    logic                  resp_ovf;
`endif

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
`ifdef SUMADOR_FLAGS_EN
        output resp_cout, resp_ovf,
`endif
        output req_ready, resp_valid, resp_data, resp_id
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready,
`ifdef SUMADOR_FLAGS_EN
        input  resp_cout, resp_ovf,
`endif
        input  req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one shared WIDTH-bit adder, one op per cycle.
// Optional macro SUMADOR_FLAGS_EN registers carry-out and signed overflow alongside the sum.
module shared_adder_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDW   = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    shared_adder_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_rr_ptr_nxt;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   r_id;
    logic             w_gnt_any;
    logic             w_can_accept;
    logic             w_load;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_data;

    // Search from rr_ptr upward modulo NREQ; first valid requester wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_gnt_any && bus.req_valid[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'(idx);
            end
        end
    end

    assign w_can_accept = (r_state == EMPTY) || bus.resp_ready;
    assign w_load       = w_can_accept && w_gnt_any && rst_n;

    always_comb begin
        w_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_ready[k] = w_load && (32'(w_gnt_id) == k);
        end
    end

    assign w_a = bus.req_a[32'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_b = bus.req_b[32'(w_gnt_id)*WIDTH +: WIDTH];

`ifdef SUMADOR_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic           w_ovf;
    logic           r_cout;
    logic           r_ovf;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_res = w_sum[WIDTH-1:0];
    assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
`else
    assign w_res = w_a + w_b;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_load) begin
            w_state_nxt  = FULL;
            w_rr_ptr_nxt = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;
        end else if ((r_state == FULL) && bus.resp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Result registers only move on a grant, so draining or backpressure leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_id   <= '0;
`ifdef SUMADOR_FLAGS_EN
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else if (w_load) begin
            r_data <= w_res;
            r_id   <= w_gnt_id;
`ifdef SUMADOR_FLAGS_EN
            r_cout <= w_sum[WIDTH];
            r_ovf  <= w_ovf;
`endif
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = (r_state == FULL);
    assign bus.resp_data  = r_data;
    assign bus.resp_id    = r_id;
`ifdef SUMADOR_FLAGS_EN
    assign bus.resp_cout  = r_cout;
    assign bus.resp_ovf   = r_ovf;
`endif
endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared WIDTH-bit adder in the RISC-V datapath.
- Typical requesters: PC+4 increment, branch-target calculation and address generation.
- Each requester issues operand pairs over a valid/ready handshake; one operation is granted per cycle.
- Result is registered with the winner's ID and held until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 3, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  packed operand B; same packing.
- req_ready  output  NREQ  one-hot grant; a transfer happens when req_valid[i] && req_ready[i].
- resp_valid  output  1  registered result valid.
- resp_data  output  WIDTH  registered sum.
- resp_id  output  IDW  index of the requester that produced resp_data.
- resp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync release): resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0, state=EMPTY.
- req_ready is forced to all-zero while rst_n=0.
- Reset mid-operation discards any held result; no response is produced for it.
- State machine, two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1, result held stable.
- can_accept = (state==EMPTY) || resp_ready.
- Grant (combinational):
  - Only when can_accept=1 and at least one req_valid bit is set.
  - Winner g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1; all other bits 0.
  - req_ready is all-zero when can_accept=0 or no request is valid.
- On grant, at the next edge:
  - resp_data <= (A_g + B_g) mod 2^WIDTH; carry-out discarded.
  - resp_id <= g; state <= FULL.
  - rr_ptr <= g+1, wrapping to 0 when g = NREQ-1.
- FULL with resp_ready=1 and a grant: back-to-back operation. The old result is consumed and the new one loaded in the same edge; throughput is 1 op/cycle.
- FULL with resp_ready=1 and no grant: state <= EMPTY, resp_valid <= 0; resp_data and resp_id keep their last value.
- FULL with resp_ready=0 (backpressure): resp_data, resp_id and resp_valid held stable; req_ready all-zero; rr_ptr unchanged.
- Latency: 1 cycle from handshake to resp_valid.
- rr_ptr advances only on a grant.
- A requester holding req_valid waits at most NREQ-1 grants before it is served.
- Requesters must not make req_valid depend on req_ready. Operands must stay stable while valid and not granted.
- Operands are sampled only in the grant cycle.

Optional Feature:
- Macro: SUMADOR_FLAGS_EN.
- Defined:
  - Adds output resp_cout (1 bit): carry out of bit WIDTH-1.
  - Adds output resp_ovf (1 bit): signed overflow, i.e. operands have equal sign bits and the sum's sign differs.
  - Both are registered alongside resp_data, reset to 0, and held under backpressure.
- Undefined: these ports do not exist; the carry is discarded.

Test Plan:
- Reset then single request: req_valid=001, A0=5, B0=7 -> req_ready=001 same cycle; next cycle resp_valid=1, resp_data=12, resp_id=0.
- Fairness: all three valid continuously, resp_ready=1, rr_ptr=0 -> grants 0,1,2,0,1 on consecutive cycles; resp_id follows one cycle later, one result per cycle.
- Backpressure: result held with resp_ready=0 for 3 cycles while req_valid=110 -> req_ready=000 throughout; resp_data/resp_id stable; after resp_ready=1, requester 1 is granted first.
- Wrap-around: A=0xFFFFFFFF, B=0x00000002 -> resp_data=0x00000001; with SUMADOR_FLAGS_EN, resp_cout=1, resp_ovf=0. A=0x7FFFFFFF, B=1 -> resp_ovf=1, resp_cout=0.
- Reset mid-operation: assert rst_n=0 while FULL with resp_data=0x1234 -> resp_valid drops immediately; after release, no stale response appears and the first grant goes to the lowest valid index.
- Idle drain: FULL, resp_ready=1, no req_valid -> next cycle resp_valid=0 and state=EMPTY; a later single request still completes in 1 cycle.
